// File: rtl/wrr4_pkg.sv
// Shared definitions for the 4-port weighted round-robin scheduler and its picker.
package wrr4_pkg;
    localparam int PORTS = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_e;
endpackage

// File: rtl/wrr4_pick.sv
// Combinational 4-way rotating-priority picker: first set req bit at ptr, ptr+1, ... wins.
module wrr4_pick
    import wrr4_pkg::*;
(
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        valid = |req;
        idx   = ptr;
        // Scan from farthest to nearest so the nearest requester overwrites last.
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req[ptr + IDX_W'(i)]) idx = ptr + IDX_W'(i);
        end
    end
endmodule

// File: rtl/wrr4_sched.sv
// 4-input weighted round-robin AXI-Stream packet scheduler; w<n> packets per turn.
// Define WRR4_STATS_EN to add per-port forwarded-packet counters stat_pkts0..3.
module wrr4_sched
    import wrr4_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int TLAST_ARB    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s0_TDATA,
    input  logic                    s0_TVALID,
    output logic                    s0_TREADY,
    input  logic                    s0_TLAST,
    input  logic [DATA_WIDTH-1:0]   s1_TDATA,
    input  logic                    s1_TVALID,
    output logic                    s1_TREADY,
    input  logic                    s1_TLAST,
    input  logic [DATA_WIDTH-1:0]   s2_TDATA,
    input  logic                    s2_TVALID,
    output logic                    s2_TREADY,
    input  logic                    s2_TLAST,
    input  logic [DATA_WIDTH-1:0]   s3_TDATA,
    input  logic                    s3_TVALID,
    output logic                    s3_TREADY,
    input  logic                    s3_TLAST,
    input  logic [WEIGHT_WIDTH-1:0] w0,
    input  logic [WEIGHT_WIDTH-1:0] w1,
    input  logic [WEIGHT_WIDTH-1:0] w2,
    input  logic [WEIGHT_WIDTH-1:0] w3,
    output logic [DATA_WIDTH-1:0]   o_TDATA,
    output logic                    o_TVALID,
    input  logic                    o_TREADY,
`ifdef WRR4_STATS_EN
    output logic [15:0]             stat_pkts0,
    output logic [15:0]             stat_pkts1,
    output logic [15:0]             stat_pkts2,
    output logic [15:0]             stat_pkts3,
`endif
    output logic                    o_TLAST
);
    logic [PORTS-1:0][DATA_WIDTH-1:0]   s_data;
    logic [PORTS-1:0][WEIGHT_WIDTH-1:0] w_arr;
    logic [PORTS-1:0]                   s_valid, s_last, s_ready, eligible;

    assign s_data  = {s3_TDATA, s2_TDATA, s1_TDATA, s0_TDATA};
    assign s_valid = {s3_TVALID, s2_TVALID, s1_TVALID, s0_TVALID};
    assign s_last  = {s3_TLAST, s2_TLAST, s1_TLAST, s0_TLAST};
    assign w_arr   = {w3, w2, w1, w0};
    assign {s3_TREADY, s2_TREADY, s1_TREADY, s0_TREADY} = s_ready;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d, ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    always_comb begin
        for (int n = 0; n < PORTS; n++) eligible[n] = s_valid[n] && (w_arr[n] != '0);
    end

    wrr4_pick u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Granted port is wired straight through; idle drives all zeros.
    always_comb begin
        o_TDATA  = '0;
        o_TVALID = 1'b0;
        o_TLAST  = 1'b0;
        s_ready  = '0;
        if (state_q != IDLE) begin
            o_TDATA           = s_data[grant_q];
            o_TVALID          = s_valid[grant_q];
            o_TLAST           = s_last[grant_q];
            s_ready[grant_q]  = o_TREADY;
        end
    end

    logic flit, last, pkt_end;
    assign flit    = o_TVALID && o_TREADY;
    assign last    = (TLAST_ARB != 0) ? o_TLAST : 1'b1;
    assign pkt_end = flit && last;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = HEAD;
                    grant_d  = pick_idx;
                    credit_d = w_arr[pick_idx];
                end
            end
            HEAD, BODY: begin
                if (pkt_end) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                    if (credit_q <= WEIGHT_WIDTH'(1)) begin
                        state_d = IDLE;
                        ptr_d   = grant_q + IDX_W'(1);
                    end else begin
                        state_d = HEAD;
                    end
                end else if (flit) begin
                    state_d = BODY;
                end else if (state_q == HEAD && !s_valid[grant_q]) begin
                    // An idle port between packets gives up the rest of its turn.
                    state_d = IDLE;
                    ptr_d   = grant_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

`ifdef WRR4_STATS_EN
    logic [PORTS-1:0][15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pkt_end) cnt_d[grant_q] = cnt_q[grant_q] + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stat_pkts0 = cnt_q[0];
    assign stat_pkts1 = cnt_q[1];
    assign stat_pkts2 = cnt_q[2];
    assign stat_pkts3 = cnt_q[3];
`endif
endmodule
